ifetch_unit: RTL and testbench

- Instruction-fetch front end of the single-cycle MIPS core. Sits directly upstream of the instruction decoder/controller.
- Owns the PC register and fetches each instruction from instruction memory over a req/ack handshake. Holds the instruction and its PC stable for decode/execute.
- On execute commit, computes the next PC from the 2-bit next-PC opcode supplied by the controller, then starts the next fetch.
- Raises a sticky fault on a misaligned PC or a fetch timeout.

---
 rtl/cpu_defs_pkg.sv | 26 ++
 rtl/npc_calc.sv | 32 +++
 rtl/ifetch_unit.sv | 112 +++++++++++
 tb/tb_ifetch_unit.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_defs_pkg.sv
// Shared definitions for the single-cycle MIPS core front end: next-PC opcodes,
// fetch FSM encoding and the default reset vector.
package cpu_defs;

   typedef enum logic [1:0] {
      NPC_PLUS4  = 2'b00,
      NPC_BRANCH = 2'b01,
      NPC_JUMP   = 2'b10,
      NPC_JR     = 2'b11
   } npc_op_e;

   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_FETCH = 2'b01,
      S_VALID = 2'b10,
      S_FAULT = 2'b11
   } fetch_state_e;

   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;

   // Word offset from a 16-bit branch immediate, already shifted to bytes.
   function automatic logic [31:0] branch_offset(input logic [15:0] imm);
      return {{14{imm[15]}}, imm, 2'b00};
   endfunction

endpackage

// File: rtl/npc_calc.sv
// Combinational next-PC generator; kept free of state so a pipelined core can
// reuse it unchanged.
module npc_calc
   import cpu_defs::*;
(
   input  logic [31:0] pc,
   input  logic [31:0] instr,
   input  logic [31:0] rs_data,
   input  logic [1:0]  npc_op,
   output logic [31:0] npc,
   output logic [31:0] pc_plus4
);

   npc_op_e op;
   logic    unused_instr_hi;

   assign op              = npc_op_e'(npc_op);
   assign pc_plus4        = pc + 32'd4;
   assign unused_instr_hi = ^instr[31:26];

   always_comb begin
      npc = pc_plus4;
      case (op)
         NPC_PLUS4:  npc = pc_plus4;
         NPC_BRANCH: npc = pc_plus4 + branch_offset(instr[15:0]);
         NPC_JUMP:   npc = {pc_plus4[31:28], instr[25:0], 2'b00};
         NPC_JR:     npc = rs_data;
         default:    npc = pc_plus4;
      endcase
   end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction-fetch front end: owns the PC, fetches over a req/ack handshake,
// holds the instruction for decode and advances on commit.
module ifetch_unit
   import cpu_defs::*;
#(
   parameter logic [31:0] RESET_PC      = DEFAULT_RESET_PC,
   parameter int          FETCH_TIMEOUT = 255
)(
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   output logic        instr_valid,
   input  logic        commit,
   input  logic [1:0]  npc_op,
   input  logic [31:0] rs_data,
   output logic [31:0] retired,
   output logic        fault
);

   if (FETCH_TIMEOUT < 1 || FETCH_TIMEOUT > 65535) begin : g_bad_timeout
      $error("ifetch_unit: FETCH_TIMEOUT out of range 1..65535");
   end

   localparam logic [15:0] TO_LAST = 16'(FETCH_TIMEOUT - 1);

   fetch_state_e state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic [31:0]  instr_q, instr_d;
   logic [31:0]  retired_q, retired_d;
   logic [15:0]  tcnt_q, tcnt_d;
   logic [31:0]  npc;

   npc_calc u_npc (
      .pc       (pc_q),
      .instr    (instr_q),
      .rs_data  (rs_data),
      .npc_op   (npc_op),
      .npc      (npc),
      .pc_plus4 (pc_plus4)
   );

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      instr_d   = instr_q;
      retired_d = retired_q;
      tcnt_d    = tcnt_q;
      case (state_q)
         S_IDLE: begin
            state_d = S_FETCH;
            tcnt_d  = '0;
         end
         S_FETCH: begin
            // An ack on the timeout boundary cycle still completes the fetch.
            if (imem_ack) begin
               instr_d = imem_rdata;
               state_d = S_VALID;
            end else if (tcnt_q == TO_LAST) begin
               state_d = S_FAULT;
            end else begin
               tcnt_d = tcnt_q + 16'd1;
            end
         end
         S_VALID: begin
            if (commit) begin
               pc_d      = npc;
               retired_d = retired_q + 32'd1;
               // Misaligned target: pc keeps the bad address for debug.
               if (npc[1:0] == 2'b00) begin
                  state_d = S_FETCH;
                  tcnt_d  = '0;
               end else begin
                  state_d = S_FAULT;
               end
            end
         end
         S_FAULT: state_d = S_FAULT;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         pc_q      <= RESET_PC;
         instr_q   <= '0;
         retired_q <= '0;
         tcnt_q    <= '0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         instr_q   <= instr_d;
         retired_q <= retired_d;
         tcnt_q    <= tcnt_d;
      end
   end

   assign imem_req    = (state_q == S_FETCH);
   assign instr_valid = (state_q == S_VALID);
   assign fault       = (state_q == S_FAULT);
   assign imem_addr   = pc_q;
   assign pc          = pc_q;
   assign instr       = instr_q;
   assign retired     = retired_q;

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: instruction table with scoreboard, then timeout,
// fault-absorption and reset-abort sequences.
module tb_ifetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] instr;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic        instr_valid;
   logic        commit;
   logic [1:0]  npc_op;
   logic [31:0] rs_data;
   logic [31:0] retired;
   logic        fault;

   always #5 clk = ~clk;

   ifetch_unit #(.RESET_PC(32'h0000_3000), .FETCH_TIMEOUT(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_rdata  (imem_rdata),
      .instr       (instr),
      .pc          (pc),
      .pc_plus4    (pc_plus4),
      .instr_valid (instr_valid),
      .commit      (commit),
      .npc_op      (npc_op),
      .rs_data     (rs_data),
      .retired     (retired),
      .fault       (fault)
   );

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
   } sb_t;
   sb_t sb_q[$];

   typedef struct {
      logic [31:0] rdata;
      logic [1:0]  op;
      logic [31:0] rs;
      int          ack_cyc;
      bit          spur;
      logic [31:0] exp_npc;
   } vec_t;
   vec_t vecs[8];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic wait_req(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (imem_req === 1'b1) begin
            ok = 1'b1;
            return;
         end
         tick();
      end
   endtask

   task automatic fetch_one(input logic [31:0] exp_pc, input logic [31:0] rdata,
                            input int ack_cyc, input bit spur);
      bit  ok;
      sb_t e;
      wait_req(ok);
      check32("req_seen", {31'd0, ok}, 32'd1);
      check32("imem_addr", imem_addr, exp_pc);
      for (int i = 1; i < ack_cyc; i++) begin
         if (spur && i == 1) begin
            commit = 1'b1;
            tick();
            commit = 1'b0;
            check32("spur_commit_pc", pc, exp_pc);
            check32("spur_commit_req", {31'd0, imem_req}, 32'd1);
         end else begin
            tick();
         end
      end
      imem_ack   = 1'b1;
      imem_rdata = rdata;
      sb_q.push_back('{pc: exp_pc, instr: rdata});
      tick();
      imem_ack   = 1'b0;
      imem_rdata = '0;
      check32("instr_valid", {31'd0, instr_valid}, 32'd1);
      if (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         check32("sb_instr", instr, e.instr);
         check32("sb_pc", pc, e.pc);
         check32("sb_pc_plus4", pc_plus4, e.pc + 32'd4);
      end else begin
         check32("sb_empty", 32'd0, 32'd1);
      end
   endtask

   logic [31:0] exp_pc;
   logic [31:0] exp_ret;

   initial begin
      //            rdata          op     rs             ack spur exp_npc
      vecs[0] = '{32'h2008_0005, 2'b00, 32'h0,         3, 0, 32'h0000_3004};
      vecs[1] = '{32'h0000_0000, 2'b00, 32'h0,         2, 1, 32'h0000_3008};
      vecs[2] = '{32'h1000_FFFF, 2'b01, 32'h0,         1, 0, 32'h0000_3008};
      vecs[3] = '{32'h1000_0003, 2'b01, 32'h0,         1, 0, 32'h0000_3018};
      vecs[4] = '{32'h0360_0008, 2'b11, 32'h0000_3010, 1, 0, 32'h0000_3010};
      vecs[5] = '{32'h0800_0C10, 2'b10, 32'h0,         1, 0, 32'h0000_3040};
      vecs[6] = '{32'h2409_0001, 2'b00, 32'h0,         4, 0, 32'h0000_3044};
      vecs[7] = '{32'h0060_0008, 2'b11, 32'h0000_3102, 1, 0, 32'h0000_3102};

      rst        = 1'b1;
      imem_ack   = 1'b0;
      imem_rdata = '0;
      commit     = 1'b0;
      npc_op     = 2'b00;
      rs_data    = '0;
      tick();
      tick();
      check32("rst_pc", pc, 32'h0000_3000);
      check32("rst_instr", instr, 32'h0);
      check32("rst_retired", retired, 32'h0);
      check32("rst_ctrl", {29'd0, imem_req, instr_valid, fault}, 32'h0);
      rst = 1'b0;

      exp_pc  = 32'h0000_3000;
      exp_ret = 32'h0;
      for (int v = 0; v < 8; v++) begin
         fetch_one(exp_pc, vecs[v].rdata, vecs[v].ack_cyc, vecs[v].spur);
         if (vecs[v].spur) begin
            imem_ack   = 1'b1;
            imem_rdata = 32'hDEAD_BEEF;
            tick();
            imem_ack   = 1'b0;
            imem_rdata = '0;
            check32("spur_ack_instr", instr, vecs[v].rdata);
            check32("spur_ack_valid", {31'd0, instr_valid}, 32'd1);
            check32("spur_retired", retired, exp_ret);
         end
         tick();
         check32("hold_pc", pc, exp_pc);
         npc_op  = vecs[v].op;
         rs_data = vecs[v].rs;
         commit  = 1'b1;
         tick();
         commit  = 1'b0;
         exp_ret = exp_ret + 32'd1;
         check32("npc", pc, vecs[v].exp_npc);
         check32("retired", retired, exp_ret);
         if (vecs[v].exp_npc[1:0] == 2'b00) begin
            check32("next_addr", imem_addr, vecs[v].exp_npc);
            check32("next_req", {31'd0, imem_req}, 32'd1);
         end else begin
            check32("jr_fault", {31'd0, fault}, 32'd1);
            check32("jr_req", {31'd0, imem_req}, 32'd0);
         end
         exp_pc = vecs[v].exp_npc;
      end

      // Fault is absorbing: ack and commit change nothing.
      imem_ack   = 1'b1;
      imem_rdata = 32'h1111_2222;
      commit     = 1'b1;
      tick();
      imem_ack   = 1'b0;
      commit     = 1'b0;
      tick();
      check32("fault_hold", {31'd0, fault}, 32'd1);
      check32("fault_pc", pc, 32'h0000_3102);
      check32("fault_retired", retired, 32'd8);
      check32("fault_instr", instr, 32'h0060_0008);

      // Timeout: no ack for FETCH_TIMEOUT cycles after entry.
      rst = 1'b1;
      tick();
      check32("rst2_fault", {31'd0, fault}, 32'd0);
      check32("rst2_pc", pc, 32'h0000_3000);
      rst = 1'b0;
      tick();
      check32("to_entry_req", {31'd0, imem_req}, 32'd1);
      tick();
      tick();
      tick();
      check32("to_not_yet", {31'd0, fault}, 32'd0);
      tick();
      check32("to_fault", {31'd0, fault}, 32'd1);
      check32("to_req_low", {31'd0, imem_req}, 32'd0);
      imem_ack   = 1'b1;
      imem_rdata = 32'h3333_4444;
      commit     = 1'b1;
      tick();
      imem_ack   = 1'b0;
      commit     = 1'b0;
      check32("to_late_instr", instr, 32'h0);
      check32("to_late_fault", {31'd0, fault}, 32'd1);

      // Reset mid-fetch; ack on the following cycle is ignored.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      tick();
      check32("ab_in_fetch", {31'd0, imem_req}, 32'd1);
      rst = 1'b1;
      tick();
      check32("ab_idle", {30'd0, imem_req, instr_valid}, 32'd0);
      check32("ab_pc", pc, 32'h0000_3000);
      rst        = 1'b0;
      imem_ack   = 1'b1;
      imem_rdata = 32'h0000_1234;
      tick();
      imem_ack   = 1'b0;
      imem_rdata = '0;
      check32("ab_ack_ignored", instr, 32'h0);
      check32("ab_no_valid", {31'd0, instr_valid}, 32'd0);
      fetch_one(32'h0000_3000, 32'h3C01_0001, 1, 1'b0);
      check32("sb_drained", sb_q.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
